// File: rtl/mips_multicycle_core_if.sv
// Unified memory bus between the multi-cycle MIPS core (master) and a word-addressed memory (slave).
interface mips_multicycle_core_if #(
  parameter int ADDR_W = 8
);
  // MemReq is the valid, MemReady the ready; an access completes on the edge where both are 1.
  // While MemReq=1 and MemReady=0 the master keeps MemAddr/MemWE/MemWData unchanged.
  logic              MemReq;
  logic              MemWE;
  logic [ADDR_W-1:0] MemAddr;
  logic [31:0]       MemWData;
  logic [31:0]       MemRData;
  logic              MemReady;

  modport master (
    output MemReq, MemWE, MemAddr, MemWData,
    input  MemRData, MemReady
  );

  modport slave (
    input  MemReq, MemWE, MemAddr, MemWData,
    output MemRData, MemReady
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: one FSM, one shared ALU, unified memory behind a req/ready bus.
// Optional MC_BNE_EN adds bne (opcode 0x05) through the BRANCH state; otherwise 0x05 halts.
module mips_multicycle_core #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  mips_multicycle_core_if.master mem,
  output logic [ADDR_W-1:0]      PC_dbg,
  output logic                   Retire,
  output logic                   Halt,
  output logic [3:0]             state_dbg
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir, a_q, b_q, alu_out, mdr;
  logic [31:0]       rf [32];
  logic              rst_hold;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sign_imm;
  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign sign_imm = {{16{ir[15]}}, ir[15:0]};

  // rst_hold keeps the bus quiet for the cycle after any reset edge, so a late MemReady is ignored.
  logic fsm_req, mem_done;
  assign fsm_req  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign mem_done = mem.MemReq && mem.MemReady;

  assign mem.MemReq   = fsm_req && !rst_hold;
  assign mem.MemWE    = (state == S_MEMWR);
  assign mem.MemAddr  = (state == S_FETCH) ? pc : alu_out[ADDR_W-1:0];
  assign mem.MemWData = (state == S_MEMWR) ? b_q : 32'h0;
  assign PC_dbg       = pc;
  assign Halt         = (state == S_HALT);
  assign state_dbg    = state;

  logic [2:0] r_ctrl, alu_ctrl;
  logic       funct_ok;
  always_comb begin
    funct_ok = 1'b1;
    r_ctrl   = 3'b010;
    case (funct)
      6'h20:   r_ctrl = 3'b010;
      6'h22:   r_ctrl = 3'b110;
      6'h24:   r_ctrl = 3'b000;
      6'h25:   r_ctrl = 3'b001;
      6'h2A:   r_ctrl = 3'b111;
      default: funct_ok = 1'b0;
    endcase
  end

  // Shared ALU: R-type ops in EXEC, address/immediate add everywhere else.
  logic [31:0] alu_b, alu_y;
  assign alu_ctrl = (state == S_EXEC) ? r_ctrl : 3'b010;
  assign alu_b    = (state == S_EXEC) ? b_q : sign_imm;
  always_comb begin
    alu_y = a_q + alu_b;
    case (alu_ctrl)
      3'b110:  alu_y = a_q - alu_b;
      3'b000:  alu_y = a_q & alu_b;
      3'b001:  alu_y = a_q | alu_b;
      3'b111:  alu_y = {31'd0, ($signed(a_q) < $signed(alu_b))};
      default: alu_y = a_q + alu_b;
    endcase
  end

  logic br_eq, br_take;
  assign br_eq = (a_q == b_q);
`ifdef MC_BNE_EN
  assign br_take = (opcode == 6'h05) ? !br_eq : br_eq;
`else
  assign br_take = br_eq;
`endif

  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    Retire  = 1'b0;
    wb_en   = 1'b0;
    wb_addr = rt;
    wb_data = alu_out;
    case (state)
      S_FETCH:  if (mem_done) state_n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:        state_n = funct_ok ? S_EXEC : S_HALT;
          6'h23, 6'h2B: state_n = S_MEMADR;
          6'h04:        state_n = S_BRANCH;
`ifdef MC_BNE_EN
          6'h05:        state_n = S_BRANCH;
`endif
          6'h08:        state_n = S_ADDIEX;
          6'h02:        state_n = S_JUMP;
          default:      state_n = S_HALT;
        endcase
      end
      S_MEMADR: state_n = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_done) state_n = S_MEMWB;
      S_MEMWB: begin
        wb_en   = 1'b1;
        wb_data = mdr;
        Retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_MEMWR: if (mem_done) begin
        Retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_EXEC:   state_n = S_ALUWB;
      S_ALUWB: begin
        wb_en   = 1'b1;
        wb_addr = rd;
        Retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_ADDIEX: state_n = S_ADDIWB;
      S_ADDIWB: begin
        wb_en   = 1'b1;
        Retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_BRANCH, S_JUMP: begin
        Retire  = 1'b1;
        state_n = S_FETCH;
      end
      default:  state_n = S_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc       <= RESET_PC;
      ir       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      rst_hold <= 1'b1;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      rst_hold <= 1'b0;
      case (state)
        S_FETCH: if (mem_done) begin
          ir <= mem.MemRData;
          pc <= pc + ADDR_W'(1);
        end
        S_DECODE: begin
          a_q <= rf[rs];
          b_q <= rf[rt];
        end
        S_MEMADR, S_EXEC, S_ADDIEX: alu_out <= alu_y;
        S_MEMRD:  if (mem_done) mdr <= mem.MemRData;
        S_BRANCH: if (br_take) pc <= pc + sign_imm[ADDR_W-1:0];
        S_JUMP:   pc <= ir[ADDR_W-1:0];
        default: ;
      endcase
      // R0 is never written, so it always reads back as zero.
      if (wb_en && (wb_addr != 5'd0)) rf[wb_addr] <= wb_data;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench for mips_multicycle_core: directed programs, expected bus accesses and retire cycles.
module tb_mips_multicycle_core;
  localparam int                ADDR_W = 8;
  localparam logic [ADDR_W-1:0] RPC    = 8'd4;

  logic              CLK   = 1'b0;
  logic              RST_N = 1'b0;
  logic [ADDR_W-1:0] PC_dbg;
  logic              Retire, Halt;
  logic [3:0]        state_dbg;

  mips_multicycle_core_if #(.ADDR_W(ADDR_W)) bus ();

  mips_multicycle_core #(.ADDR_W(ADDR_W), .RESET_PC(RPC)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .mem       (bus),
    .PC_dbg    (PC_dbg),
    .Retire    (Retire),
    .Halt      (Halt),
    .state_dbg (state_dbg)
  );

  // clock / cycle counter (cycle 1 is the first cycle after the reset-release edge)
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= RST_N ? cyc + 1 : 0;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // scoreboard state
  logic [40:0] exp_q[$];
  logic [15:0] ret_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
  endfunction

  // memory slave: data region (addr >= 0x40) inserts data_wait stall cycles per access
  logic [31:0] mem_arr [256];
  int data_wait = 0;
  initial begin
    int wcnt;
    wcnt = 0;
    bus.MemReady = 1'b0;
    bus.MemRData = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (RST_N && bus.MemReq) begin
        if ((bus.MemAddr >= 8'h40) && (wcnt < data_wait)) begin
          bus.MemReady = 1'b0;
          wcnt++;
        end else begin
          bus.MemReady = 1'b1;
          bus.MemRData = mem_arr[bus.MemAddr];
          wcnt = 0;
        end
      end else begin
        bus.MemReady = 1'b0;
        wcnt = 0;
      end
    end
  end

  // monitor: completed accesses, bus stability during stalls, retire pulses
  initial begin
    logic        stall_q;
    logic [40:0] stall_bus, cur, e;
    logic [15:0] r;
    stall_q = 1'b0;
    stall_bus = '0;
    forever begin
      @(negedge CLK);
      cur = {bus.MemWE, bus.MemAddr, bus.MemWData};
      if (!RST_N) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_req", 64'(bus.MemReq), 64'(1));
          check("hold_bus", 64'(cur), 64'(stall_bus));
        end
        if (bus.MemReq && bus.MemReady) begin
          check("access_expected", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_access", 64'(cur), 64'(e));
          end
        end
        if (Retire) begin
          check("retire_expected", 64'(ret_q.size() > 0), 64'(1));
          if (ret_q.size() > 0) begin
            r = ret_q.pop_front();
            check("retire_cycle", 64'(cyc), 64'(r));
          end
        end
        stall_q   = bus.MemReq && !bus.MemReady;
        stall_bus = cur;
      end
    end
  end

  // driver helpers
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
  endfunction
  function automatic void exp_f(input int a);
    exp_q.push_back({1'b0, a[7:0], 32'h0});
  endfunction
  function automatic void exp_w(input int a, input logic [31:0] d);
    exp_q.push_back({1'b1, a[7:0], d});
  endfunction
  function automatic void exp_ret(input int c);
    ret_q.push_back(c[15:0]);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hFC00_0000;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    @(negedge CLK);
    check("req_after_rst_edge", 64'(bus.MemReq), 64'(0));
    @(negedge CLK);
    check("rst_pc",     64'(PC_dbg),       64'(RPC));
    check("rst_addr",   64'(bus.MemAddr),  64'(RPC));
    check("rst_req",    64'(bus.MemReq),   64'(0));
    check("rst_we",     64'(bus.MemWE),    64'(0));
    check("rst_wdata",  64'(bus.MemWData), 64'(0));
    check("rst_halt",   64'(Halt),         64'(0));
    check("rst_retire", 64'(Retire),       64'(0));
    check("rst_state",  64'(state_dbg),    64'(0));
    exp_q.delete();
    ret_q.delete();
  endtask

  task automatic release_rst();
    #2 RST_N = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || (ret_q.size() != 0)) && (n < 300)) begin
      @(negedge CLK);
      #2;
      n++;
    end
    check(name, 64'(exp_q.size() + ret_q.size()), 64'(0));
  endtask

  task automatic halt_check(input string name, input int pc);
    repeat (3) @(negedge CLK);
    #2;
    check({name, "_halt"}, 64'(Halt),       64'(1));
    check({name, "_req"},  64'(bus.MemReq), 64'(0));
    check({name, "_pc"},   64'(PC_dbg),     64'(pc));
  endtask

  initial begin
    // A: addi/addi/add/sw then illegal opcode
    do_reset();
    clear_mem();
    data_wait = 0;
    mem_arr[4] = enc_i(8, 0, 1, 5);
    mem_arr[5] = enc_i(8, 0, 2, 7);
    mem_arr[6] = enc_r(1, 2, 3, 'h20);
    mem_arr[7] = enc_i('h2B, 0, 3, 'h10);
    exp_f(4); exp_f(5); exp_f(6); exp_f(7); exp_w('h10, 32'd12); exp_f(8);
    exp_ret(4); exp_ret(8); exp_ret(12); exp_ret(16);
    release_rst();
    wait_drain("a_drain");
    halt_check("a", 9);

    // B: lw with 3 wait states, slt/sub/and/or, stores, R0 write, address truncation
    do_reset();
    clear_mem();
    data_wait = 3;
    mem_arr['h41] = 32'hFFFF_FFF0;
    mem_arr[4]  = enc_i('h23, 0, 4, 'h41);
    mem_arr[5]  = enc_i(8, 0, 5, -3);
    mem_arr[6]  = enc_r(4, 5, 6, 'h2A);
    mem_arr[7]  = enc_r(5, 4, 7, 'h22);
    mem_arr[8]  = enc_r(4, 5, 8, 'h24);
    mem_arr[9]  = enc_r(4, 5, 9, 'h25);
    mem_arr[10] = enc_i('h2B, 0, 6, 'h42);
    mem_arr[11] = enc_i('h2B, 0, 7, 'h143);
    mem_arr[12] = enc_i('h2B, 0, 8, 'h44);
    mem_arr[13] = enc_i('h2B, 0, 9, 'h45);
    mem_arr[14] = enc_i(8, 0, 0, 9);
    mem_arr[15] = enc_i('h2B, 0, 0, 'h46);
    exp_f(4); exp_f('h41);
    for (int a = 5; a <= 10; a++) exp_f(a);
    exp_w('h42, 32'd1);          exp_f(11);
    exp_w('h43, 32'd13);         exp_f(12);
    exp_w('h44, 32'hFFFF_FFF0);  exp_f(13);
    exp_w('h45, 32'hFFFF_FFFD);  exp_f(14); exp_f(15);
    exp_w('h46, 32'd0);          exp_f(16);
    exp_ret(8); exp_ret(12); exp_ret(16); exp_ret(20); exp_ret(24); exp_ret(28);
    exp_ret(35); exp_ret(42); exp_ret(49); exp_ret(56); exp_ret(60); exp_ret(67);
    release_rst();
    wait_drain("b_drain");
    halt_check("b", 17);

    // C: beq not taken, j, bne (taken when enabled, halt otherwise), beq taken forward
    do_reset();
    clear_mem();
    data_wait = 0;
    mem_arr[4]  = enc_i(8, 0, 1, 3);
    mem_arr[5]  = enc_i(8, 0, 2, 4);
    mem_arr[6]  = enc_i(4, 1, 2, 5);
    mem_arr[7]  = {6'h02, 26'd10};
    mem_arr[10] = enc_i(5, 1, 2, -3);
    mem_arr[8]  = enc_i(4, 0, 0, 3);
    exp_f(4); exp_f(5); exp_f(6); exp_f(7); exp_f(10);
    exp_ret(4); exp_ret(8); exp_ret(11); exp_ret(14);
`ifdef MC_BNE_EN
    exp_f(8); exp_f(12);
    exp_ret(17); exp_ret(20);
    release_rst();
    wait_drain("c_drain");
    halt_check("c", 13);
`else
    release_rst();
    wait_drain("c_drain");
    halt_check("c", 11);
`endif

    // D: beq taken with imm=-1 at PC=6 refetches 6
    do_reset();
    clear_mem();
    mem_arr[4] = enc_i(8, 0, 1, 3);
    mem_arr[5] = enc_i(8, 0, 2, 3);
    mem_arr[6] = enc_i(4, 1, 2, -1);
    exp_f(4); exp_f(5); exp_f(6); exp_f(6);
    exp_ret(4); exp_ret(8); exp_ret(11);
    release_rst();
    wait_drain("d_drain");

    // E: reset while a store is stalled; the store never completes, core refetches RESET_PC
    do_reset();
    clear_mem();
    data_wait = 100;
    mem_arr[4] = enc_i(8, 0, 1, 'h55);
    mem_arr[5] = enc_i('h2B, 0, 1, 'h40);
    exp_f(4); exp_f(5);
    exp_ret(4);
    release_rst();
    wait_drain("e1_drain");
    repeat (5) @(negedge CLK);
    #2;
    check("e_stall_req",   64'(bus.MemReq),   64'(1));
    check("e_stall_we",    64'(bus.MemWE),    64'(1));
    check("e_stall_addr",  64'(bus.MemAddr),  64'(8'h40));
    check("e_stall_wdata", 64'(bus.MemWData), 64'(32'h55));
    do_reset();
    data_wait = 0;
    exp_f(4); exp_f(5); exp_w('h40, 32'h55); exp_f(6);
    exp_ret(4); exp_ret(8);
    release_rst();
    wait_drain("e2_drain");
    halt_check("e", 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
